// File: rtl/scan_config_reg.sv
// WIDTH-bit scannable configuration register: serial shift stage, shadow (update)
// stage driving the fabric, and a three-state session FSM. rst is active-low, async.
module scan_config_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             wen,
    input  logic             scan_en,
    input  logic             scan_valid,
    input  logic             scan_in,
    output logic             scan_out,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_abort
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            q_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            q_q     <= q_d;
            count_q <= count_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        q_d     = q_q;
        count_d = count_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Keep the shift stage mirroring the shadow so readback starts from live config
                shift_d = q_q;
                if (scan_en) begin
                    state_d = SHIFT;
                    count_d = '0;
                end else if (wen) begin
                    q_d     = D;
                    shift_d = D;
                end
            end

            SHIFT: begin
                if (!scan_en) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (scan_valid) begin
                    shift_d = {scan_in, shift_q[WIDTH-1:1]};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_BIT) begin
                        state_d = UPDATE;
                    end
                end
            end

            UPDATE: begin
                q_d     = shift_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign scan_out  = shift_q[0];
    assign Q         = q_q;
    assign busy      = (state_q == SHIFT) || (state_q == UPDATE);
    assign cfg_done  = done_q;
    assign cfg_abort = abort_q;

endmodule

// File: tb/tb_scan_config_reg.sv
// Directed, table-driven bench for scan_config_reg plus hand sequences for stall,
// asynchronous reset mid-session and a two-instance daisy chain.
module tb_scan_config_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d = '0;
    logic       wen = 1'b0;
    logic       scan_en = 1'b0;
    logic       scan_valid = 1'b0;
    logic       scan_in = 1'b0;
    logic       scan_out;
    logic [7:0] q;
    logic       busy, cfg_done, cfg_abort;

    logic       c_en = 1'b0;
    logic       c_v = 1'b0;
    logic       c_si = 1'b0;
    logic       a_so, b_so;
    logic [7:0] a_q, b_q;
    logic       a_busy, b_busy, a_done, b_done, a_abort, b_abort;
    logic [7:0] zero8 = '0;
    logic       zero1 = 1'b0;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    scan_config_reg #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .D(d), .wen(wen), .scan_en(scan_en),
        .scan_valid(scan_valid), .scan_in(scan_in), .scan_out(scan_out),
        .Q(q), .busy(busy), .cfg_done(cfg_done), .cfg_abort(cfg_abort)
    );

    scan_config_reg #(.WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .D(zero8), .wen(zero1), .scan_en(c_en),
        .scan_valid(c_v), .scan_in(c_si), .scan_out(a_so),
        .Q(a_q), .busy(a_busy), .cfg_done(a_done), .cfg_abort(a_abort)
    );

    scan_config_reg #(.WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .D(zero8), .wen(zero1), .scan_en(c_en),
        .scan_valid(c_v), .scan_in(a_so), .scan_out(b_so),
        .Q(b_q), .busy(b_busy), .cfg_done(b_done), .cfg_abort(b_abort)
    );

    typedef struct {
        logic       wen;
        logic [7:0] d;
        logic       en;
        logic       v;
        logic       si;
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       abort;
        logic       so;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic w, input logic [7:0] dd, input logic e, input logic v,
                       input logic s, input logic [7:0] eq, input logic eb, input logic edn,
                       input logic eab, input logic eso);
        vec_t r;
        r.wen = w; r.d = dd; r.en = e; r.v = v; r.si = s;
        r.q = eq; r.busy = eb; r.done = edn; r.abort = eab; r.so = eso;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] c3;
        logic [7:0] f0;
        logic [7:0] h34;
        logic [7:0] h12;
        int unsigned done_at;
        int unsigned pulses;
        logic hold_ok;
        int unsigned cyc;

        c3 = 8'h3C;
        f0 = 8'hF0;
        h34 = 8'h34;
        h12 = 8'h12;

        // Parallel write, then a full continuous F0 session
        add(1, 8'h3C, 0, 0, 0, 8'h3C, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 8'h3C, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 8'h00, 1, 1, f0[i], 8'h3C, 1, 0, 0, (i < 7) ? c3[i+1] : f0[0]);
        add(0, 8'h00, 0, 0, 0, 8'hF0, 0, 1, 0, 0);
        add(1, 8'h3C, 0, 0, 0, 8'h3C, 0, 0, 0, 0);
        // Abort after 5 bits
        add(0, 8'h00, 1, 0, 0, 8'h3C, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 8'h00, 1, 1, 1, 8'h3C, 1, 0, 0, c3[i+1]);
        add(0, 8'h00, 0, 1, 1, 8'h3C, 0, 0, 1, c3[5]);
        add(0, 8'h00, 0, 0, 0, 8'h3C, 0, 0, 0, 0);
        // scan_en beats wen; wen ignored in SHIFT
        add(1, 8'hFF, 1, 0, 0, 8'h3C, 1, 0, 0, 0);
        add(1, 8'hFF, 1, 0, 0, 8'h3C, 1, 0, 0, 0);
        add(1, 8'hFF, 1, 1, 1, 8'h3C, 1, 0, 0, c3[1]);
        add(0, 8'h00, 0, 0, 0, 8'h3C, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 8'h3C, 0, 0, 0, 0);
        // Abort on the cycle that would have carried the last bit
        add(0, 8'h00, 1, 0, 0, 8'h3C, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            add(0, 8'h00, 1, 1, 1, 8'h3C, 1, 0, 0, c3[i+1]);
        add(0, 8'h00, 0, 1, 1, 8'h3C, 0, 0, 1, c3[7]);
        add(0, 8'h00, 0, 0, 0, 8'h3C, 0, 0, 0, 0);

        // Reset state
        #12;
        chk("reset_outputs", {q, busy, cfg_done, cfg_abort, scan_out}, {8'h00, 4'b0000});
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            wen = vecs[i].wen; d = vecs[i].d; scan_en = vecs[i].en;
            scan_valid = vecs[i].v; scan_in = vecs[i].si;
            tick();
            chk($sformatf("vec%0d", i), {q, busy, cfg_done, cfg_abort, scan_out},
                {vecs[i].q, vecs[i].busy, vecs[i].done, vecs[i].abort, vecs[i].so});
        end
        wen = 1'b0; scan_en = 1'b0; scan_valid = 1'b0; scan_in = 1'b0;

        // Stalled session: valid on every other cycle, Q must hold 3C until the single done pulse
        scan_en = 1'b1;
        tick();
        chk("stall_enter_busy", {31'd0, busy}, 32'd1);
        done_at = 0; pulses = 0; hold_ok = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            cyc = t - 1;
            if (cyc < 16 && (cyc % 2) == 0) begin
                scan_valid = 1'b1;
                scan_in = f0[cyc/2];
            end else begin
                scan_valid = 1'b0;
                scan_in = 1'b0;
            end
            if (cyc >= 15) scan_en = 1'b0;
            tick();
            if (cfg_done) begin
                pulses++;
                if (done_at == 0) done_at = t;
            end else if (done_at == 0 && q !== 8'h3C) begin
                hold_ok = 1'b0;
            end
        end
        chk("stall_done_cycle", done_at, 16);
        chk("stall_done_pulses", pulses, 1);
        chk("stall_q_held", {31'd0, hold_ok}, 32'd1);
        chk("stall_q_final", {24'd0, q}, {24'd0, 8'hF0});

        // Asynchronous reset in the middle of a session
        wen = 1'b1; d = 8'hA5;
        tick();
        wen = 1'b0; scan_en = 1'b1;
        tick();
        scan_valid = 1'b1; scan_in = 1'b1;
        tick();
        tick();
        scan_valid = 1'b0;
        chk("pre_reset_state", {q, busy, scan_out}, {8'hA5, 1'b1, 1'b1});
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", {q, busy, scan_out, cfg_done, cfg_abort}, {8'h00, 4'b0000});
        scan_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_reset_idle", {q, busy, cfg_done, cfg_abort}, {8'h00, 3'b000});

        // Two-instance chain: 16'h1234 LSB first over two back-to-back sessions
        c_en = 1'b1; c_v = 1'b0;
        tick();
        c_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c_si = h34[i];
            tick();
        end
        c_si = 1'b0;
        tick();
        chk("chain1_q", {a_q, b_q}, {8'h34, 8'h00});
        chk("chain1_done", {a_done, b_done}, 2'b11);
        tick();
        chk("chain_restart_busy", {a_busy, b_busy}, 2'b11);
        for (int i = 0; i < 8; i++) begin
            c_si = h12[i];
            tick();
        end
        c_si = 1'b0; c_en = 1'b0; c_v = 1'b0;
        tick();
        chk("chain2_q", {a_q, b_q}, {8'h12, 8'h34});
        chk("chain2_done", {a_done, b_done}, 2'b11);
        tick();
        chk("chain_idle", {a_busy, b_busy, a_done, b_done, a_abort, b_abort}, 6'b000000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
